neo_frame_sequencer: RTL and testbench

- Upstream feeder for the NeoPixel strand controller.
- Generates a rotating colour pattern and streams it into the controller one colour byte at a time, using the pixel_index/color_index/color_level/load_color handshake.
- Issues send_it once every pixel is loaded, waits a programmable frame period, advances the rotation and repeats.
- Replaces tie-off logic at chip level as the driver of the controller's load/send inputs.

---
 rtl/neo_pkg.sv | 49 ++++
 rtl/neo_palette_lookup.sv | 35 +++
 rtl/neo_frame_sequencer.sv | 156 +++++++++++++++
 tb/tb_neo_frame_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/neo_pkg.sv
// Shared types and the eight-entry RGB palette for the NeoPixel frame sequencer.
package neo_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      GREEN = 2'd0,
      RED   = 2'd1,
      BLUE  = 2'd2
   } color_idx_t;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD_WAIT  = 3'd1,
      LOAD_PULSE = 3'd2,
      LOAD_GAP   = 3'd3,
      SEND_WAIT  = 3'd4,
      SEND       = 3'd5,
      HOLD       = 3'd6
   } seq_state_t;

   localparam rgb_t PALETTE [8] = '{
      24'hFF0000,   // red
      24'h00FF00,   // green
      24'h0000FF,   // blue
      24'hFFFF00,   // yellow
      24'h00FFFF,   // cyan
      24'hFF00FF,   // magenta
      24'h404040,   // white (dimmed)
      24'h000000    // off
   };

   // Strand wire order is G, R, B; index 3 is never loaded and reads as dark.
   function automatic logic [7:0] pick_channel(input rgb_t c, input logic [1:0] col);
      logic [7:0] v;
      case (col)
         GREEN:   v = c.g;
         RED:     v = c.r;
         BLUE:    v = c.b;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/neo_palette_lookup.sv
// Combinational colour-byte lookup: rotated palette entry for a pixel, one channel.
// With BRIGHTNESS_SCALE_EN defined the byte is right-shifted by LEVEL_SHIFT.
module neo_palette_lookup
   import neo_pkg::*;
#(
   parameter int NUM_PIXELS  = 5,
   parameter int LEVEL_SHIFT = 2
) (
   input  logic [2:0] pix,
   input  logic [2:0] offset,
   input  logic [1:0] col,
   output logic [7:0] level
);

`ifdef BRIGHTNESS_SCALE_EN
   localparam bit SCALE_EN = 1'b1;
`else
   localparam bit SCALE_EN = 1'b0;
`endif

   localparam logic [3:0] NP = 4'(NUM_PIXELS);

   logic [3:0] sum;
   logic [2:0] idx;
   logic [7:0] raw;

   // pix and offset are both below NUM_PIXELS, so one conditional subtract is a full modulo.
   always_comb begin
      sum   = {1'b0, pix} + {1'b0, offset};
      idx   = (sum >= NP) ? 3'(sum - NP) : sum[2:0];
      raw   = pick_channel(PALETTE[idx], col);
      level = SCALE_EN ? (raw >> LEVEL_SHIFT) : raw;
   end

endmodule

// File: rtl/neo_frame_sequencer.sv
// Streams a rotating palette pattern into the NeoPixel controller, then sends and holds.
// Optional BRIGHTNESS_SCALE_EN macro dims every level (applied in neo_palette_lookup).
module neo_frame_sequencer
   import neo_pkg::*;
#(
   parameter int NUM_PIXELS   = 5,
   parameter int FRAME_CYCLES = 2_500_000,
   parameter int LEVEL_SHIFT  = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       ready_to_load,
   input  logic       ready_to_send,
   output logic [2:0] pixel_index,
   output logic [1:0] color_index,
   output logic [7:0] color_level,
   output logic       load_color,
   output logic       send_it,
   output logic       frame_done,
   output logic [2:0] fsm_state
);

   localparam int               CNT_W     = $clog2(FRAME_CYCLES + 1);
   localparam logic [2:0]       LAST_PIX  = 3'(NUM_PIXELS - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(FRAME_CYCLES - 1);

   seq_state_t       state, state_nxt;
   logic [2:0]       pix, pix_nxt;
   logic [1:0]       col, col_nxt;
   logic [2:0]       offset, offset_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       pixel_index_nxt;
   logic [1:0]       color_index_nxt;
   logic [7:0]       color_level_nxt;
   logic             load_nxt, send_nxt, done_nxt;
   logic [7:0]       level;

   neo_palette_lookup #(
      .NUM_PIXELS  (NUM_PIXELS),
      .LEVEL_SHIFT (LEVEL_SHIFT)
   ) u_lookup (
      .pix    (pix),
      .offset (offset),
      .col    (col),
      .level  (level)
   );

   assign fsm_state = state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pix         <= '0;
         col         <= '0;
         offset      <= '0;
         cnt         <= '0;
         pixel_index <= '0;
         color_index <= '0;
         color_level <= '0;
         load_color  <= 1'b0;
         send_it     <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state       <= state_nxt;
         pix         <= pix_nxt;
         col         <= col_nxt;
         offset      <= offset_nxt;
         cnt         <= cnt_nxt;
         pixel_index <= pixel_index_nxt;
         color_index <= color_index_nxt;
         color_level <= color_level_nxt;
         load_color  <= load_nxt;
         send_it     <= send_nxt;
         frame_done  <= done_nxt;
      end
   end

   // Strobes are computed one cycle early so every output comes straight from a flop.
   always_comb begin
      state_nxt       = state;
      pix_nxt         = pix;
      col_nxt         = col;
      offset_nxt      = offset;
      cnt_nxt         = cnt;
      pixel_index_nxt = pixel_index;
      color_index_nxt = color_index;
      color_level_nxt = color_level;
      load_nxt        = 1'b0;
      send_nxt        = 1'b0;
      done_nxt        = 1'b0;

      case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = LOAD_WAIT;
               pix_nxt   = '0;
               col_nxt   = '0;
            end
         end
         LOAD_WAIT: begin
            if (ready_to_load) begin
               pixel_index_nxt = pix;
               color_index_nxt = col;
               color_level_nxt = level;
               load_nxt        = 1'b1;
               state_nxt       = LOAD_PULSE;
            end
         end
         LOAD_PULSE: begin
            state_nxt = LOAD_GAP;
         end
         LOAD_GAP: begin
            state_nxt = LOAD_WAIT;
            if (col == 2'd2) begin
               col_nxt = '0;
               if (pix == LAST_PIX) begin
                  pix_nxt   = '0;
                  state_nxt = SEND_WAIT;
               end else begin
                  pix_nxt = pix + 3'd1;
               end
            end else begin
               col_nxt = col + 2'd1;
            end
         end
         SEND_WAIT: begin
            if (ready_to_send) begin
               send_nxt  = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            cnt_nxt   = HOLD_LOAD;
            state_nxt = HOLD;
            if (FRAME_CYCLES == 1) done_nxt = 1'b1;
         end
         HOLD: begin
            // frame_done is raised so that it is high during the final (cnt == 0) hold cycle.
            if (cnt == '0) begin
               offset_nxt = (offset == LAST_PIX) ? 3'd0 : offset + 3'd1;
               pix_nxt    = '0;
               col_nxt    = '0;
               state_nxt  = enable ? LOAD_WAIT : IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) done_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// Directed self-checking bench for neo_frame_sequencer (NUM_PIXELS=5, FRAME_CYCLES=10).
module tb_neo_frame_sequencer;

   localparam int NP = 5;
   localparam int FC = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       ready_to_load = 1'b0;
   logic       ready_to_send = 1'b0;
   logic [2:0] pixel_index;
   logic [1:0] color_index;
   logic [7:0] color_level;
   logic       load_color;
   logic       send_it;
   logic       frame_done;
   logic [2:0] fsm_state;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [12:0] load_q [$];
   int          load_cyc_q [$];
   int load_total = 0, send_cnt = 0, done_cnt = 0, overlap_cnt = 0;
   int last_send_cyc = 0, last_done_cyc = 0, frames_expected = 0;
   int first_load_cyc = 0, rel_cyc = 0;

   neo_frame_sequencer #(
      .NUM_PIXELS   (NP),
      .FRAME_CYCLES (FC),
      .LEVEL_SHIFT  (2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .ready_to_load (ready_to_load),
      .ready_to_send (ready_to_send),
      .pixel_index   (pixel_index),
      .color_index   (color_index),
      .color_level   (color_level),
      .load_color    (load_color),
      .send_it       (send_it),
      .frame_done    (frame_done),
      .fsm_state     (fsm_state)
   );

   // clock / reset block
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // observe strobes on the falling edge, away from the active edge
   always @(negedge clock) begin
      if (reset) begin
         if (load_color) begin
            load_q.push_back({pixel_index, color_index, color_level});
            load_cyc_q.push_back(cyc);
            load_total++;
         end
         if (send_it) begin
            send_cnt++;
            last_send_cyc = cyc;
         end
         if (frame_done) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (load_color && send_it) overlap_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Reference palette, independent of the RTL package.
   function automatic logic [7:0] exp_level(input int p, input int c, input int off);
      logic [23:0] rgb;
      logic [7:0]  v;
      case ((p + off) % NP)
         0: rgb = 24'hFF0000;
         1: rgb = 24'h00FF00;
         2: rgb = 24'h0000FF;
         3: rgb = 24'hFFFF00;
         4: rgb = 24'h00FFFF;
         5: rgb = 24'hFF00FF;
         6: rgb = 24'h404040;
         default: rgb = 24'h000000;
      endcase
      case (c)
         0: v = rgb[15:8];
         1: v = rgb[23:16];
         default: v = rgb[7:0];
      endcase
`ifdef BRIGHTNESS_SCALE_EN
      v = v >> 2;
`endif
      return v;
   endfunction

   task automatic check_frame(input int off, input bit timed);
      int          waited = 0;
      logic [12:0] got;
      int          c0 = 0;
      int          cprev = 0;
      frames_expected++;
      while ((load_q.size() < 3*NP || send_cnt < frames_expected) && waited < 3000) begin
         @(posedge clock);
         waited++;
      end
      check_eq($sformatf("frame%0d_loads", frames_expected), load_q.size(), 3*NP);
      check_eq($sformatf("frame%0d_sent", frames_expected), send_cnt, frames_expected);
      for (int i = 0; i < 3*NP && load_q.size() > 0; i++) begin
         got = load_q.pop_front();
         c0  = load_cyc_q.pop_front();
         if (i == 0) first_load_cyc = c0;
         check_eq($sformatf("load%0d_off%0d", i, off), got,
                  {3'(i / 3), 2'(i % 3), exp_level(i / 3, i % 3, off)});
         if (timed && i > 0) check_eq($sformatf("spacing%0d", i), c0 - cprev, 3);
         cprev = c0;
      end
      if (timed) check_eq("load_to_send", last_send_cyc - cprev, 3);
      waited = 0;
      while (done_cnt < frames_expected && waited < 100) begin
         @(posedge clock);
         waited++;
      end
      check_eq("frame_done_cnt", done_cnt, frames_expected);
      check_eq("send_to_done", last_done_cyc - last_send_cyc, FC);
   endtask

   initial begin
      int w;
      enable        = 1'b1;
      ready_to_load = 1'b1;
      ready_to_send = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_load", load_color, 0);
      check_eq("rst_send", send_it, 0);
      check_eq("rst_done", frame_done, 0);
      check_eq("rst_pix", pixel_index, 0);
      check_eq("rst_col", color_index, 0);
      check_eq("rst_lvl", color_level, 0);
      check_eq("rst_state", fsm_state, 0);

      @(negedge clock);
      reset   = 1'b1;
      rel_cyc = cyc;
      check_frame(0, 1'b1);
      check_eq("release_to_load", first_load_cyc - rel_cyc, 2);

      // frame 1: stall ready_to_load after pixel 1 colour 0
      w = 0;
      while (load_total < 19 && w < 500) begin
         @(posedge clock);
         w++;
      end
      #1 ready_to_load = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      check_eq("stall_no_load", load_total, 19);
      check_eq("stall_strobe", load_color, 0);
      check_eq("stall_pix", pixel_index, 1);
      check_eq("stall_col", color_index, 0);
      check_eq("stall_lvl", color_level, exp_level(1, 0, 1));
      ready_to_load = 1'b1;
      check_frame(1, 1'b0);

      // frames 2..5; frame 5 wraps the offset back to 0
      for (int f = 2; f <= 5; f++) check_frame(f % NP, 1'b1);

      // frame 6: drop enable while pixel 2 is loading
      w = 0;
      while (load_total < 6*15 + 7 && w < 500) begin
         @(posedge clock);
         w++;
      end
      #1 enable = 1'b0;
      check_frame(1, 1'b1);
      repeat (40) @(posedge clock);
      #1;
      check_eq("idle_no_load", load_total, 105);
      check_eq("idle_no_send", send_cnt, 7);
      check_eq("idle_state", fsm_state, 0);

      // reset in LOAD_PULSE
      enable = 1'b1;
      w = 0;
      do begin
         @(posedge clock);
         #1;
         w++;
      end while (load_color !== 1'b1 && w < 100);
      check_eq("pulse_seen", load_color, 1);
      check_eq("pulse_state", fsm_state, 2);
      reset = 1'b0;
      #1;
      check_eq("async_load_clr", load_color, 0);
      check_eq("async_state", fsm_state, 0);
      check_eq("async_pix", pixel_index, 0);
      load_q.delete();
      load_cyc_q.delete();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset   = 1'b1;
      rel_cyc = cyc;
      check_frame(0, 1'b1);
      check_eq("rerelease_to_load", first_load_cyc - rel_cyc, 2);

      check_eq("no_overlap", overlap_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
